// File: rtl/fp_addsub_pipe.sv
// Three-stage floating-point adder/subtractor with valid/ready handshake.
// Define FP_ADDSUB_RNE_EN for round-to-nearest-even; otherwise truncates and saturates on overflow.
module fp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 7,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid_in,
    output logic         ready_in,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic         valid_out,
    input  logic         ready_out,
    output logic [W-1:0] result,
    output logic [3:0]   flags
);
    localparam int XW  = MAN_W + 4;          // hidden + fraction + guard/round/sticky
    localparam int SW  = XW + 1;             // plus carry-out
    localparam int EW  = EXP_W + 2;          // signed working exponent
    localparam int SHW = $clog2(XW + 1);
    localparam logic [EXP_W-1:0] EMAX = '1;
    localparam logic signed [EW-1:0] EMAX_S = $signed({2'b00, EMAX});
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef struct packed {
        logic             spec;
        logic [W-1:0]     spec_res;
        logic [3:0]       spec_flg;
        logic             sgn_l;
        logic             sgn_s;
        logic [EXP_W-1:0] exp_l;
        logic [MAN_W:0]   man_l;
        logic [MAN_W:0]   man_s;
        logic [EXP_W-1:0] ediff;
    } s1_t;

    typedef struct packed {
        logic             spec;
        logic [W-1:0]     spec_res;
        logic [3:0]       spec_flg;
        logic             sgn_l;
        logic             sgn_s;
        logic [EXP_W-1:0] exp_l;
        logic [SW-1:0]    sum;
    } s2_t;

    logic [3:1] vld_pipe;
    logic       en1, en2, en3;
    s1_t        s1_d, s1_q;
    s2_t        s2_d, s2_q;
    logic [W-1:0] res_d;
    logic [3:0]   flg_d;

    assign en3       = !vld_pipe[3] || ready_out;
    assign en2       = !vld_pipe[2] || en3;
    assign en1       = !vld_pipe[1] || en2;
    assign ready_in  = rst_n && en1;
    assign valid_out = vld_pipe[3];

    // S1: unpack, specials, order operands by magnitude
    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] ma, mb;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, swap;
    logic [W-2:0]     mag_a, mag_b;

    always_comb begin
        sa     = a[W-1];
        sb     = b[W-1] ^ sub;
        ea     = a[W-2:MAN_W];
        eb     = b[W-2:MAN_W];
        ma     = a[MAN_W-1:0];
        mb     = b[MAN_W-1:0];
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        a_inf  = (ea == EMAX) && (ma == '0);
        b_inf  = (eb == EMAX) && (mb == '0);
        a_nan  = (ea == EMAX) && (ma != '0);
        b_nan  = (eb == EMAX) && (mb != '0);
        mag_a  = a_zero ? '0 : a[W-2:0];
        mag_b  = b_zero ? '0 : b[W-2:0];
        swap   = mag_b > mag_a;

        s1_d          = '0;
        s1_d.sgn_l    = swap ? sb : sa;
        s1_d.sgn_s    = swap ? sa : sb;
        s1_d.exp_l    = swap ? eb : ea;
        s1_d.man_l    = swap ? {!b_zero, b_zero ? '0 : mb} : {!a_zero, a_zero ? '0 : ma};
        s1_d.man_s    = swap ? {!a_zero, a_zero ? '0 : ma} : {!b_zero, b_zero ? '0 : mb};
        s1_d.ediff    = swap ? (eb - ea) : (ea - eb);
        if (a_nan || b_nan) begin
            s1_d.spec     = 1'b1;
            s1_d.spec_res = QNAN;
        end else if (a_inf && b_inf && (sa != sb)) begin
            s1_d.spec     = 1'b1;
            s1_d.spec_res = QNAN;
            s1_d.spec_flg = 4'b1000;
        end else if (a_inf) begin
            s1_d.spec     = 1'b1;
            s1_d.spec_res = {sa, EMAX, {MAN_W{1'b0}}};
        end else if (b_inf) begin
            s1_d.spec     = 1'b1;
            s1_d.spec_res = {sb, EMAX, {MAN_W{1'b0}}};
        end
    end

    // S2: align smaller operand (shift capped, lost bits folded into sticky), then add/sub
    logic [SHW-1:0] shamt;
    logic [XW-1:0]  xs, xl, al;

    always_comb begin
        shamt = (s1_q.ediff > EXP_W'(MAN_W + 3)) ? SHW'(MAN_W + 3) : s1_q.ediff[SHW-1:0];
        xs    = {s1_q.man_s, 3'b000};
        xl    = {s1_q.man_l, 3'b000};
        al    = xs >> shamt;
        al[0] = al[0] | ((al << shamt) != xs);

        s2_d          = '0;
        s2_d.spec     = s1_q.spec;
        s2_d.spec_res = s1_q.spec_res;
        s2_d.spec_flg = s1_q.spec_flg;
        s2_d.sgn_l    = s1_q.sgn_l;
        s2_d.sgn_s    = s1_q.sgn_s;
        s2_d.exp_l    = s1_q.exp_l;
        s2_d.sum      = (s1_q.sgn_l ^ s1_q.sgn_s) ? ({1'b0, xl} - {1'b0, al})
                                                  : ({1'b0, xl} + {1'b0, al});
    end

    // S3: normalise, round, pack
    logic [SHW-1:0]        lz;
    logic                  found;
    logic [XW-1:0]         norm;
    logic signed [EW-1:0]  exp_n, exp_r;
    logic [MAN_W+1:0]      mant_r;
    logic [MAN_W-1:0]      frac;
    logic                  rnd_up, inexact;

    always_comb begin
        lz    = '0;
        found = 1'b0;
        for (int i = XW - 1; i >= 0; i--) begin
            if (!found && s2_q.sum[i]) begin
                lz    = SHW'(XW - 1 - i);
                found = 1'b1;
            end
        end
        if (s2_q.sum[SW-1]) begin
            norm  = {s2_q.sum[SW-1:2], s2_q.sum[1] | s2_q.sum[0]};
            exp_n = $signed({2'b00, s2_q.exp_l}) + EW'(1);
        end else begin
            norm  = s2_q.sum[XW-1:0] << lz;
            exp_n = $signed({2'b00, s2_q.exp_l}) - $signed({{(EW-SHW){1'b0}}, lz});
        end
        inexact = |norm[2:0];
`ifdef FP_ADDSUB_RNE_EN
        rnd_up = norm[2] && (norm[1] || norm[0] || norm[3]);
`else
        rnd_up = 1'b0;
`endif
        mant_r = {1'b0, norm[XW-1:3]} + {{(MAN_W+1){1'b0}}, rnd_up};
        if (mant_r[MAN_W+1]) begin
            exp_r = exp_n + EW'(1);
            frac  = mant_r[MAN_W:1];
        end else begin
            exp_r = exp_n;
            frac  = mant_r[MAN_W-1:0];
        end

        res_d = '0;
        flg_d = '0;
        if (s2_q.spec) begin
            res_d = s2_q.spec_res;
            flg_d = s2_q.spec_flg;
        end else if (s2_q.sum == '0) begin
            res_d = {s2_q.sgn_l & s2_q.sgn_s, {(W-1){1'b0}}};
        end else if (exp_r >= EMAX_S) begin
`ifdef FP_ADDSUB_RNE_EN
            res_d = {s2_q.sgn_l, EMAX, {MAN_W{1'b0}}};
`else
            res_d = {s2_q.sgn_l, EMAX - 1'b1, {MAN_W{1'b1}}};
`endif
            flg_d = 4'b0101;
        end else if (exp_r <= 0) begin
            res_d = {s2_q.sgn_l, {(W-1){1'b0}}};
            flg_d = 4'b0011;
        end else begin
            res_d = {s2_q.sgn_l, exp_r[EXP_W-1:0], frac};
            flg_d = {3'b000, inexact};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            s1_q     <= '0;
            s2_q     <= '0;
            result   <= '0;
            flags    <= '0;
        end else begin
            if (en1) begin
                vld_pipe[1] <= valid_in;
                if (valid_in) s1_q <= s1_d;
            end
            if (en2) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) s2_q <= s2_d;
            end
            if (en3) begin
                vld_pipe[3] <= vld_pipe[2];
                if (vld_pipe[2]) begin
                    result <= res_d;
                    flags  <= flg_d;
                end
            end
        end
    end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe (BF16 defaults); expectations follow FP_ADDSUB_RNE_EN.
module tb_fp_addsub_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic        ready_in;
    logic [15:0] a, b;
    logic        sub;
    logic        valid_out;
    logic        ready_out;
    logic [15:0] result;
    logic [3:0]  flags;

    int checks = 0;
    int errors = 0;

    fp_addsub_pipe dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_in(ready_in),
        .a(a), .b(b), .sub(sub), .valid_out(valid_out), .ready_out(ready_out),
        .result(result), .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                          input logic isub, input logic [15:0] er, input logic [3:0] ef);
        int lat;
        a = ia; b = ib; sub = isub; valid_in = 1'b1; ready_out = 1'b1;
        #1;
        chk({tag, "_rdy"}, 32'(ready_in), 32'd1);
        step();
        valid_in = 1'b0;
        lat = 1;
        while (!valid_out && lat < 10) begin
            step();
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'd3);
        chk({tag, "_res"}, 32'(result), 32'(er));
        chk({tag, "_flg"}, 32'(flags), 32'(ef));
    endtask

    logic [15:0] opa [6] = '{16'h3F80, 16'h4000, 16'h4040, 16'h4080, 16'h40A0, 16'h40C0};
    logic [15:0] exq [6] = '{16'h4000, 16'h4040, 16'h4080, 16'h40A0, 16'h40C0, 16'h40E0};

    initial begin
        int  idx, got;
        logic rdy, seen;
        rst_n = 1'b0; valid_in = 1'b0; a = '0; b = '0; sub = 1'b0; ready_out = 1'b1;
        repeat (3) step();
        chk("rst_vout", 32'(valid_out), 32'd0);
        chk("rst_res", 32'(result), 32'd0);
        chk("rst_flg", 32'(flags), 32'd0);
        chk("rst_rdy", 32'(ready_in), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_rdy", 32'(ready_in), 32'd1);

        run_op("one_plus_two", 16'h3F80, 16'h4000, 1'b0, 16'h4040, 4'b0000);
        run_op("cancel",       16'h3F80, 16'h3F80, 1'b1, 16'h0000, 4'b0000);
        run_op("zero_plus",    16'h0000, 16'h3F80, 1'b0, 16'h3F80, 4'b0000);
        run_op("three_m_one",  16'h4040, 16'h3F80, 1'b1, 16'h4000, 4'b0000);
        run_op("neg_result",   16'h3F80, 16'h4000, 1'b1, 16'hBF80, 4'b0000);
        run_op("negz_negz",    16'h8000, 16'h8000, 1'b0, 16'h8000, 4'b0000);
        run_op("negz_sub_z",   16'h8000, 16'h0000, 1'b1, 16'h8000, 4'b0000);
        run_op("subn_flush",   16'h0001, 16'h3F80, 1'b0, 16'h3F80, 4'b0000);
        run_op("inf_m_inf",    16'h7F80, 16'hFF80, 1'b0, 16'h7FC0, 4'b1000);
        run_op("nan_in",       16'h7FC1, 16'h3F80, 1'b0, 16'h7FC0, 4'b0000);
        run_op("ninf_plus",    16'hFF80, 16'h3F80, 1'b0, 16'hFF80, 4'b0000);
        run_op("underflow",    16'h0081, 16'h0080, 1'b1, 16'h0000, 4'b0011);
`ifdef FP_ADDSUB_RNE_EN
        run_op("ovf",          16'h7F7F, 16'h7F7F, 1'b0, 16'h7F80, 4'b0101);
        run_op("tie_even",     16'h3F80, 16'h3B80, 1'b0, 16'h3F80, 4'b0001);
        run_op("tie_odd",      16'h3F81, 16'h3B80, 1'b0, 16'h3F82, 4'b0001);
        run_op("rnd_carry_ovf", 16'h7F7F, 16'h7B00, 1'b0, 16'h7F80, 4'b0101);
`else
        run_op("ovf",          16'h7F7F, 16'h7F7F, 1'b0, 16'h7F7F, 4'b0101);
        run_op("tie_even",     16'h3F80, 16'h3B80, 1'b0, 16'h3F80, 4'b0001);
        run_op("tie_odd",      16'h3F81, 16'h3B80, 1'b0, 16'h3F81, 4'b0001);
        run_op("rnd_carry_ovf", 16'h7F7F, 16'h7B00, 1'b0, 16'h7F7F, 4'b0001);
`endif
        step();

        // backpressure: output blocked for 5 cycles while 6 ops are offered
        ready_out = 1'b0; b = 16'h3F80; sub = 1'b0; idx = 0;
        for (int c = 0; c < 5; c++) begin
            a = opa[idx]; valid_in = 1'b1;
            #1;
            rdy = ready_in;
            if (c >= 3) chk("stall_rdy_low", 32'(rdy), 32'd0);
            step();
            if (rdy) idx++;
        end
        chk("stall_accepted", 32'(idx), 32'd3);
        chk("stall_hold_v", 32'(valid_out), 32'd1);
        chk("stall_hold_res", 32'(result), 32'h4000);
        ready_out = 1'b1; got = 0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            valid_in = (idx < 6);
            if (idx < 6) a = opa[idx];
            #1;
            rdy = ready_in && valid_in;
            if (valid_out) begin
                chk($sformatf("order_%0d", got), 32'(result), 32'(exq[got]));
                got++;
            end
            step();
            if (rdy) idx++;
        end
        valid_in = 1'b0;
        chk("order_count", 32'(got), 32'd6);
        seen = 1'b0;
        repeat (4) begin
            if (valid_out) seen = 1'b1;
            step();
        end
        chk("no_dup", 32'(seen), 32'd0);

        // reset with three operations in flight
        for (int k = 0; k < 3; k++) begin
            a = opa[k]; valid_in = 1'b1;
            step();
        end
        valid_in = 1'b0;
        chk("inflight_v", 32'(valid_out), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rdy", 32'(ready_in), 32'd0);
        step();
        chk("mid_rst_vout", 32'(valid_out), 32'd0);
        chk("mid_rst_res", 32'(result), 32'd0);
        chk("mid_rst_flg", 32'(flags), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_rdy", 32'(ready_in), 32'd1);
        seen = 1'b0;
        repeat (5) begin
            step();
            if (valid_out) seen = 1'b1;
        end
        chk("post_rst_quiet", 32'(seen), 32'd0);
        run_op("post_rst_op", 16'h3F80, 16'h4000, 1'b0, 16'h4040, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
